// File: rtl/multi_clock_divider.sv
// multi_clock_divider: NUM_CH independent run-time programmable clock dividers with end-of-period tick.
// Defining CLKDIV_SYNC_EN adds a global `sync` strobe that phase-aligns every channel.
module multi_clock_divider_ch #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_load,
  input  logic             i_sync,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_clk,
  output logic             o_tick
);
  logic [DIV_W-1:0] r_cnt, r_act, r_pend;
  logic             r_pvld;
  logic [DIV_W-1:0] w_ld_div, w_hi, w_last;
  logic             w_wrap;

  assign w_ld_div = (i_div < DIV_W'(2)) ? DIV_W'(2) : i_div;
  assign w_hi     = r_act >> 1;
  assign w_last   = r_act - DIV_W'(1);
  assign w_wrap   = (r_cnt == w_last);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_act  <= DIV_W'(DEFAULT_DIV);
      r_pend <= DIV_W'(DEFAULT_DIV);
      r_pvld <= 1'b0;
      o_clk  <= 1'b0;
      o_tick <= 1'b0;
    end else begin
      if (i_load) r_pend <= w_ld_div;
      if (i_sync || !i_en) begin
        // Idle or phase-align: apply any pending divisor now, a same-edge load stays pending.
        r_cnt  <= i_en ? DIV_W'(1) : '0;
        o_clk  <= i_en;
        o_tick <= 1'b0;
        if (r_pvld) r_act <= r_pend;
        r_pvld <= i_load;
      end else begin
        o_clk  <= (r_cnt < w_hi);
        o_tick <= w_wrap;
        if (w_wrap) begin
          // Period boundary: a load on this very edge beats the older pending value.
          r_cnt  <= '0;
          r_pvld <= 1'b0;
          if (i_load)      r_act <= w_ld_div;
          else if (r_pvld) r_act <= r_pend;
        end else begin
          r_cnt <= r_cnt + DIV_W'(1);
          if (i_load) r_pvld <= 1'b1;
        end
      end
    end
  end
endmodule

module multi_clock_divider #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                    clk_in,
  input  logic                    reset,
`ifdef CLKDIV_SYNC_EN
  input  logic                    sync,
`endif
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*DIV_W-1:0] div_in,
  input  logic [NUM_CH-1:0]       load,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick
);
  logic [NUM_CH-1:0][DIV_W-1:0] w_div;
  logic                         w_sync;

  assign w_div = div_in;
`ifdef CLKDIV_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    multi_clock_divider_ch #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk_in(clk_in),
      .reset (reset),
      .i_en  (en[g]),
      .i_load(load[g]),
      .i_sync(w_sync),
      .i_div (w_div[g]),
      .o_clk (clk_out[g]),
      .o_tick(tick[g])
    );
  end
endmodule
